// File: rtl/gray_cnt_pkg.sv
// Shared constants and Gray/binary conversion helpers for the gray counter family.
// Helpers work on GRAY_MAX_W bits; callers zero-extend and truncate to their own width.
package gray_cnt_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam int GRAY_MAX_W = 32;

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Upper zero bits leave the low bits unaffected, so narrower codes convert correctly.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary decoder: XOR prefix scan starting at the MSB.
module gray2bin #(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    always_comb begin
        bin = '0;
        bin[WIDTH-1] = gray[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
    end

endmodule

// File: rtl/gray_counter_param.sv
// Parametrised up/down Gray counter with wrap/saturate, sticky flags and registered output.
// Define GRAY_CNT_LOAD_EN to add the Load_En/Load_Gray synchronous load path.
module gray_counter_param
    import gray_cnt_pkg::*;
#(
    parameter int WIDTH    = 3,
    parameter bit SATURATE = 1'b0
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Clear,
    input  logic             En,
    input  logic             Dir,
`ifdef GRAY_CNT_LOAD_EN
    input  logic             Load_En,
    input  logic [WIDTH-1:0] Load_Gray,
`endif
    output logic [WIDTH-1:0] Output,
    output logic             Overflow,
    output logic             Underflow,
    output logic             Tc
);

    localparam logic [WIDTH-1:0] BIN_MAX = '1;
    localparam logic [WIDTH-1:0] BIN_ONE = WIDTH'(1);

    logic [WIDTH-1:0] bin;
    logic [WIDTH-1:0] next_bin;
    logic [WIDTH-1:0] next_gray;
    logic             next_ovf;
    logic             next_udf;
    logic             next_tc;

`ifdef GRAY_CNT_LOAD_EN
    logic [WIDTH-1:0] load_bin;

    gray2bin #(.WIDTH(WIDTH)) u_load_dec (
        .gray (Load_Gray),
        .bin  (load_bin)
    );
`endif

    always_comb begin
        next_bin = bin;
        next_ovf = Overflow;
        next_udf = Underflow;
        next_tc  = 1'b0;
        if (Clear) begin
            next_bin = '0;
            next_ovf = 1'b0;
            next_udf = 1'b0;
`ifdef GRAY_CNT_LOAD_EN
        end else if (Load_En) begin
            next_bin = load_bin;
`endif
        end else if (En) begin
            if (Dir == DIR_UP) begin
                if (bin == BIN_MAX) begin
                    next_bin = SATURATE ? BIN_MAX : '0;
                    next_ovf = 1'b1;
                    next_tc  = 1'b1;
                end else begin
                    next_bin = bin + BIN_ONE;
                end
            end else begin
                if (bin == '0) begin
                    next_bin = SATURATE ? '0 : BIN_MAX;
                    next_udf = 1'b1;
                    next_tc  = 1'b1;
                end else begin
                    next_bin = bin - BIN_ONE;
                end
            end
        end
    end

    // Gray is derived from next_bin so Output is a clean register driving CDC consumers.
    assign next_gray = WIDTH'(bin2gray(GRAY_MAX_W'(next_bin)));

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            bin       <= '0;
            Output    <= '0;
            Overflow  <= 1'b0;
            Underflow <= 1'b0;
            Tc        <= 1'b0;
        end else begin
            bin       <= next_bin;
            Output    <= next_gray;
            Overflow  <= next_ovf;
            Underflow <= next_udf;
            Tc        <= next_tc;
        end
    end

endmodule
